// File: rtl/ham_pkg.sv
// Shared Hamming(15,11) definitions: word widths, data-to-position map and the
// reference encoder used by both the encoder RTL and the corrector bench.
package ham_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;

  // d[i] lands at codeword position DATA_POS[i]; positions 1,2,4,8 carry parity
  localparam int DATA_POS [1:DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [CODE_W:1] ham_encode(input logic [DATA_W:1] data);
    logic [CODE_W:1] code;
    logic            par;
    code = '0;
    for (int i = 1; i <= DATA_W; i++) begin
      code[DATA_POS[i]] = data[i];
    end
    // parity slots are still zero here, so XOR over every covered position is safe
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int j = 1; j <= CODE_W; j++) begin
        if ((j & (1 << k)) != 0) par = par ^ code[j];
      end
      code[1 << k] = par;
    end
    return code;
  endfunction

endpackage

// File: rtl/ham_fifo.sv
// Small valid/ready FIFO with registered occupancy; full flag depends only on
// stored state, so a pop frees a slot for the following cycle.
module ham_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_OCC);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & o_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ham_encoder.sv
// Streaming Hamming(15,11) encoder with optional per-word single-bit error
// injection, buffered on a valid/ready output.
module ham_encoder
  import ham_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W:1]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        inject_pos,
  output logic [CODE_W:1]   out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_count
);

  logic              w_full;
  logic              w_accept;
  logic [CODE_W:1]   w_flip;
  logic [CODE_W:1]   w_code;
  logic [CNT_W-1:0]  r_word_count;

  // held low during reset so nothing is accepted while the buffer clears
  assign in_ready = ~reset & ~w_full;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_flip = '0;
    if (inject_pos != 4'd0) w_flip[inject_pos] = 1'b1;
  end

  assign w_code = ham_encode(in_data) ^ w_flip;

  ham_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_accept),
    .i_push_data (w_code),
    .o_full      (w_full),
    .i_pop       (out_ready),
    .o_valid     (out_valid),
    .o_data      (out_code)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_count <= '0;
    end else if (w_accept) begin
      r_word_count <= r_word_count + CNT_W'(1);
    end
  end

  assign word_count = r_word_count;

endmodule

// File: tb/tb_ham_encoder.sv
// Scoreboard bench for ham_encoder: accepted words queue their expected codeword,
// a negedge monitor pops and compares whenever the DUT hands a word downstream.
module tb_ham_encoder;

  logic         clock;
  logic         reset;
  logic [11:1]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   inject_pos;
  logic [15:1]  out_code;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  word_count;

  ham_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inject_pos (inject_pos),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:1] code;
    logic [3:0]  inj;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  logic [15:1] exp_code;
  bit          rnd_or;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // independent encoder written straight from the parity equations
  function automatic logic [15:1] enc_model(input logic [11:1] d);
    logic [15:1] c;
    c = '0;
    c[3]  = d[1];  c[5]  = d[2];  c[6]  = d[3];  c[7]  = d[4];
    c[9]  = d[5];  c[10] = d[6];  c[11] = d[7];  c[12] = d[8];
    c[13] = d[9];  c[14] = d[10]; c[15] = d[11];
    c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4] = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8] = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    return c;
  endfunction

  function automatic logic [3:0] syndrome(input logic [15:1] c);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 1; i <= 15; i++) begin
      if (c[i]) s = s ^ 4'(i);
    end
    return s;
  endfunction

  // monitor: pop first, then record any word accepted at the coming edge
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_code), 32'hFFFF_FFFF);
        end else begin
          m_e = q.pop_front();
          chk("codeword", 32'(out_code), 32'(m_e.code));
          chk("syndrome", 32'(syndrome(out_code)), 32'(m_e.inj));
        end
      end
      if (in_valid && in_ready) q.push_back('{exp_code, inject_pos});
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic [11:1] d, input logic [3:0] inj, input logic [15:1] e);
    bit ok;
    in_data    = d;
    inject_pos = inj;
    exp_code   = e;
    in_valid   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
      if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) cycles(1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:1] d;
    logic [3:0]  inj;
    n_cmp = 0; n_bad = 0; rnd_or = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; inject_pos = '0;
    out_ready = 1'b1; exp_code = '0;

    // reset state
    cycles(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic vectors, one-cycle latency from empty
    send(11'h000, 4'd0, 15'h0000);
    in_valid = 1'b0;
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_code", 32'(out_code), 32'h0000);
    cycles(2);
    send(11'h7FF, 4'd0, 15'h7FFF);
    send(11'h001, 4'd0, 15'h0007);
    send(11'h001, 4'd5, 15'h0017);
    in_valid = 1'b0;
    drain();

    // backpressure: two fill the buffer, third waits for the first pop
    out_ready = 1'b0;
    send(11'h002, 4'd0, 15'h0019);
    send(11'h004, 4'd0, 15'h002A);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(word_count), 32'd6);
    in_data = 11'h400; inject_pos = 4'd0; exp_code = 15'h408B; in_valid = 1'b1;
    cycles(1);
    chk("stall_out_code", 32'(out_code), 32'h0019);
    out_ready = 1'b1;
    @(negedge clock);
    chk("pop_cycle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    chk("after_pop_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    drain();
    chk("count_after_bp", 32'(word_count), 32'd7);

    // random stream with random backpressure
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    rnd_or = 1'b1;
    for (int n = 0; n < 300; n++) begin
      d   = 11'($urandom_range(0, 2047));
      inj = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      send(d, inj, enc_model(d) ^ ((inj == 4'd0) ? 15'h0000 : (15'h0001 << (inj - 4'd1))));
    end
    in_valid = 1'b0;
    rnd_or = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("stream_word_count", 32'(word_count), 32'd300);

    // reset with two words buffered
    out_ready = 1'b0;
    send(11'h0AA, 4'd0, enc_model(11'h0AA));
    send(11'h155, 4'd0, enc_model(11'h155));
    in_valid = 1'b0;
    chk("buffered_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    cycles(1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    send(11'h001, 4'd0, 15'h0007);
    in_valid = 1'b0;
    chk("first_after_rst", 32'(out_code), 32'h0007);
    drain();
    chk("final_word_count", 32'(word_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
